// File: rtl/field_merge_writer.sv
// field_merge_writer: inserts a 1..8-bit field from data_in into an IO byte via read-modify-write.
// Latency: io_wr/done in cycle N+2+IO_RD_LAT after start at edge N (N+1 for len==0, no read).
// Backpressure: none; start is only sampled in IDLE, requests while busy are dropped.
// Optional feature macro: FIELD_MERGE_PARITY_EN adds registered odd-parity output io_wpar.
module field_merge_writer #(
  // Cycles from io_rd high to io_rdata valid; legal range 1..3.
  parameter int IO_RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic [2:0] pos,
  input  logic [2:0] len,
  input  logic [7:0] io_rdata,
  output logic       io_rd,
  output logic       io_wr,
  output logic [7:0] io_wdata,
  output logic       busy,
  output logic       done
`ifdef FIELD_MERGE_PARITY_EN
  ,
  output logic       io_wpar
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_WR   = 2'd3;

  // Last WAIT count value; io_rdata is valid in the WAIT cycle where cnt reaches it.
  localparam logic [1:0] LAT_LAST = 2'(IO_RD_LAT - 1);

  logic [1:0] state;
  logic [1:0] cnt;
  logic [7:0] data_q;
  logic [2:0] pos_q;
  logic [2:0] len_q;

  logic [7:0] fmask;
  logic [7:0] fdata;
  logic [7:0] merged;
  logic       wdata_load;
  logic [7:0] wdata_next;

  // Rotate left modulo 8: upper byte of the doubled value shifted left.
  function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] s);
    logic [15:0] t;
    t = {x, x} << s;
    return t[15:8];
  endfunction

  // Field mask and data aligned to the destination position; field may wrap past bit 7.
  always_comb begin
    fmask  = rotl8(8'hFF >> (4'd8 - {1'b0, len_q}), pos_q);
    fdata  = rotl8(data_q, pos_q);
    merged = (io_rdata & ~fmask) | (fdata & fmask);
  end

  // Write-data register load: full byte straight from IDLE, merged byte at end of WAIT.
  always_comb begin
    wdata_load = 1'b0;
    wdata_next = merged;
    if (state == ST_IDLE && start && len == 3'd0) begin
      wdata_load = 1'b1;
      wdata_next = data_in;
    end else if (state == ST_WAIT && cnt == LAT_LAST) begin
      wdata_load = 1'b1;
      wdata_next = merged;
    end
  end

  // Transfer sequencer: IDLE -> RD -> WAIT -> WR, or IDLE -> WR for a full-byte write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= 2'd0;
      data_q <= 8'h00;
      pos_q  <= 3'd0;
      len_q  <= 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            data_q <= data_in;
            pos_q  <= pos;
            len_q  <= len;
            state  <= (len == 3'd0) ? ST_WR : ST_RD;
          end
        end
        ST_RD: begin
          cnt   <= 2'd0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt == LAT_LAST) begin
            state <= ST_WR;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Write data holds between writes so the bus sees a stable value.
  always_ff @(posedge clk) begin
    if (rst) begin
      io_wdata <= 8'h00;
    end else if (wdata_load) begin
      io_wdata <= wdata_next;
    end
  end

`ifdef FIELD_MERGE_PARITY_EN
  // Odd parity tracked alongside io_wdata; reset value matches parity of 8'h00.
  always_ff @(posedge clk) begin
    if (rst) begin
      io_wpar <= 1'b1;
    end else if (wdata_load) begin
      io_wpar <= ~^wdata_next;
    end
  end
`endif

  // Strobes decode directly from the registered state, so rd and wr are mutually exclusive.
  always_comb begin
    io_rd = (state == ST_RD);
    io_wr = (state == ST_WR);
    done  = (state == ST_WR);
    busy  = (state != ST_IDLE);
  end

endmodule

// File: tb/tb_field_merge_writer.sv
// Directed bench for field_merge_writer: one instance at IO_RD_LAT=1, one at IO_RD_LAT=3.
// A small IO model returns the old byte only in the cycle it is due, garbage otherwise.
// Expected values are hand-computed constants.
module tb_field_merge_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start1 = 1'b0;
  logic       start3 = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [2:0] pos = 3'd0;
  logic [2:0] len = 3'd0;
  logic [7:0] old_v = 8'h00;

  logic [7:0] io_rdata1, io_rdata3;
  logic       io_rd1, io_wr1, busy1, done1;
  logic       io_rd3, io_wr3, busy3, done3;
  logic [7:0] io_wdata1, io_wdata3;
  logic       wpar1, wpar3;

  logic [2:0] pipe1 = 3'd0;
  logic [2:0] pipe3 = 3'd0;

  int n_checks = 0;
  int n_err    = 0;
  bit sel3     = 1'b0;

  always #5 clk = ~clk;

  field_merge_writer #(.IO_RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start1), .data_in(data_in), .pos(pos), .len(len),
    .io_rdata(io_rdata1), .io_rd(io_rd1), .io_wr(io_wr1), .io_wdata(io_wdata1),
    .busy(busy1), .done(done1)
`ifdef FIELD_MERGE_PARITY_EN
    , .io_wpar(wpar1)
`endif
  );

  field_merge_writer #(.IO_RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .data_in(data_in), .pos(pos), .len(len),
    .io_rdata(io_rdata3), .io_rd(io_rd3), .io_wr(io_wr3), .io_wdata(io_wdata3),
    .busy(busy3), .done(done3)
`ifdef FIELD_MERGE_PARITY_EN
    , .io_wpar(wpar3)
`endif
  );

`ifndef FIELD_MERGE_PARITY_EN
  assign wpar1 = 1'b0;
  assign wpar3 = 1'b0;
`endif

  // IO model: read data appears exactly IO_RD_LAT cycles after io_rd, inverted otherwise.
  always @(posedge clk) begin
    pipe1 <= {pipe1[1:0], io_rd1};
    pipe3 <= {pipe3[1:0], io_rd3};
  end
  assign io_rdata1 = pipe1[0] ? old_v : ~old_v;
  assign io_rdata3 = pipe3[2] ? old_v : ~old_v;

  wire       m_rd    = sel3 ? io_rd3    : io_rd1;
  wire       m_wr    = sel3 ? io_wr3    : io_wr1;
  wire       m_done  = sel3 ? done3     : done1;
  wire       m_busy  = sel3 ? busy3     : busy1;
  wire [7:0] m_wdata = sel3 ? io_wdata3 : io_wdata1;
  wire       m_wpar  = sel3 ? wpar3     : wpar1;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Runs one transfer; start at edge N, observes cycles N+1..N+12.
  task automatic xfer(input bit use3, input logic [7:0] old, input logic [7:0] d,
                      input logic [2:0] p, input logic [2:0] l, input bit hold,
                      output int rd_c, output int wr_c, output int wr_n,
                      output logic [7:0] wd, output logic wp, output bit done_ok,
                      output bit overlap, output logic busy_wr, output logic busy_after);
    rd_c = -1; wr_c = -1; wr_n = 0; wd = 8'h00; wp = 1'b0;
    done_ok = 1'b1; overlap = 1'b0; busy_wr = 1'b0; busy_after = 1'b1;
    @(negedge clk);
    sel3 = use3; old_v = old; data_in = d; pos = p; len = l;
    if (use3) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (m_rd && rd_c < 0) rd_c = k;
      if (m_wr) begin
        wr_n++;
        if (wr_c < 0) begin
          wr_c = k; wd = m_wdata; wp = m_wpar; busy_wr = m_busy;
        end
      end
      if (m_done !== m_wr) done_ok = 1'b0;
      if (m_rd && m_wr) overlap = 1'b1;
      if (wr_c > 0 && k == wr_c + 1) busy_after = m_busy;
      if (use3) start3 = hold && m_busy; else start1 = hold && m_busy;
    end
    start1 = 1'b0; start3 = 1'b0;
  endtask

  int rd_c, wr_c, wr_n, wr3_cnt;
  logic [7:0] wd;
  logic wp, busy_wr, busy_after;
  bit done_ok, overlap;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_io_rd", io_rd1, 0);
    chk("rst_io_wr", io_wr1, 0);
    chk("rst_wdata", io_wdata1, 8'h00);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    rst = 1'b0;
`ifdef FIELD_MERGE_PARITY_EN
    chk("rst_wpar", wpar1, 1);
`endif

    // Basic merge: old FF, field 3'b101 at pos 2.
    xfer(0, 8'hFF, 8'h05, 3'd2, 3'd3, 0, rd_c, wr_c, wr_n, wd, wp, done_ok, overlap, busy_wr, busy_after);
    chk("s1_rd_cycle", rd_c, 1);
    chk("s1_wr_cycle", wr_c, 3);
    chk("s1_wdata", wd, 8'hF7);
    chk("s1_wr_count", wr_n, 1);
    chk("s1_done_eq_wr", done_ok, 1);
    chk("s1_rd_wr_overlap", overlap, 0);
    chk("s1_busy_in_wr", busy_wr, 1);
    chk("s1_busy_after", busy_after, 0);
`ifdef FIELD_MERGE_PARITY_EN
    chk("s1_wpar", wp, 0);
`endif

    // Wrapping field: pos 6, len 4 covers bits 7,6,1,0.
    xfer(0, 8'h00, 8'h0F, 3'd6, 3'd4, 0, rd_c, wr_c, wr_n, wd, wp, done_ok, overlap, busy_wr, busy_after);
    chk("wrap_wdata", wd, 8'hC3);
    chk("wrap_wr_cycle", wr_c, 3);

    // Full byte: no read, write in N+1.
    xfer(0, 8'h3C, 8'hA5, 3'd5, 3'd0, 0, rd_c, wr_c, wr_n, wd, wp, done_ok, overlap, busy_wr, busy_after);
    chk("full_no_rd", rd_c, -1);
    chk("full_wr_cycle", wr_c, 1);
    chk("full_wdata", wd, 8'hA5);
    chk("full_done_eq_wr", done_ok, 1);
    chk("full_wdata_hold", io_wdata1, 8'hA5);

    // Single bit at pos 7; upper data bits must be ignored.
    xfer(0, 8'h00, 8'hFF, 3'd7, 3'd1, 0, rd_c, wr_c, wr_n, wd, wp, done_ok, overlap, busy_wr, busy_after);
    chk("bit7_wdata", wd, 8'h80);

    // Mixed old byte to see both halves of the merge.
    xfer(0, 8'h5A, 8'hF3, 3'd1, 3'd4, 0, rd_c, wr_c, wr_n, wd, wp, done_ok, overlap, busy_wr, busy_after);
    chk("mix_wdata", wd, 8'h46);

    // start held high through the whole transfer, including the WR cycle.
    xfer(0, 8'hFF, 8'h05, 3'd2, 3'd3, 1, rd_c, wr_c, wr_n, wd, wp, done_ok, overlap, busy_wr, busy_after);
    chk("hold_wr_count", wr_n, 1);
    chk("hold_wdata", wd, 8'hF7);

    // Longer read latency.
    xfer(1, 8'hFF, 8'h05, 3'd2, 3'd3, 0, rd_c, wr_c, wr_n, wd, wp, done_ok, overlap, busy_wr, busy_after);
    chk("lat3_rd_cycle", rd_c, 1);
    chk("lat3_wr_cycle", wr_c, 5);
    chk("lat3_wdata", wd, 8'hF7);
    chk("lat3_overlap", overlap, 0);
`ifdef FIELD_MERGE_PARITY_EN
    chk("lat3_wpar", wp, 0);
`endif

    // Reset while in WAIT aborts the transfer with no write.
    @(negedge clk);
    sel3 = 1'b1; old_v = 8'h00; data_in = 8'h0F; pos = 3'd0; len = 3'd4;
    start3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start3 = 1'b0;
    @(negedge clk);
    chk("abort_in_wait_busy", busy3, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy3, 0);
    chk("abort_io_rd", io_rd3, 0);
    chk("abort_io_wr", io_wr3, 0);
    chk("abort_wdata", io_wdata3, 8'h00);
    chk("abort_done", done3, 0);
    wr3_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (io_wr3) wr3_cnt++;
    end
    chk("abort_no_write", wr3_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
